// File: rtl/shift_frame_ctrl_if.sv
// Serial-bit source / parallel-word consumer bundle for shift_frame_ctrl.
// The master drives bits and accepts frames; the slave (the controller) produces frames.
interface shift_frame_ctrl_if #(
    parameter int unsigned WIDTH = 6
);
    logic             din;
    logic             en;
    logic             frame_ready;
    logic [WIDTH-1:0] frame;
    logic             frame_valid;
    logic             busy;
    logic             parity_err;
    logic             overrun;

    modport master (
        output din,
        output en,
        output frame_ready,
        input  frame,
        input  frame_valid,
        input  busy,
        input  parity_err,
        input  overrun
    );

    modport slave (
        input  din,
        input  en,
        input  frame_ready,
        output frame,
        output frame_valid,
        output busy,
        output parity_err,
        output overrun
    );
endinterface

// File: rtl/shift_frame_ctrl.sv
// Start-bit framed serial-to-parallel receiver: shifts WIDTH bits MSB-first,
// checks optional even parity and holds the word under a valid/ready handshake.
module shift_frame_ctrl #(
    parameter int unsigned WIDTH     = 6,
    parameter bit          PARITY_EN = 1'b1
) (
    input logic               clk,
    input logic               rst,
    shift_frame_ctrl_if.slave bus
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StPar,
        StHold
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [CntW-1:0]  r_cnt;
    logic [CntW-1:0]  w_cnt_d;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_d;
    logic [WIDTH-1:0] r_frame;
    logic [WIDTH-1:0] w_frame_d;
    logic             r_valid;
    logic             w_valid_d;
    logic             r_busy;
    logic             w_busy_d;
    logic             r_perr;
    logic             w_perr_d;
    logic             r_overrun;
    logic             w_overrun_d;

    logic             w_start;
    logic [WIDTH-1:0] w_shifted;

    assign w_start   = bus.en & bus.din;
    assign w_shifted = {r_sh[WIDTH-2:0], bus.din};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_frame   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_sh      <= w_sh_d;
            r_frame   <= w_frame_d;
            r_valid   <= w_valid_d;
            r_busy    <= w_busy_d;
            r_perr    <= w_perr_d;
            r_overrun <= w_overrun_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_sh_d      = r_sh;
        w_frame_d   = r_frame;
        w_valid_d   = r_valid;
        w_perr_d    = r_perr;
        w_overrun_d = r_overrun;

        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d = StShift;
                    w_cnt_d   = '0;
                end
            end

            StShift: begin
                if (bus.en) begin
                    w_sh_d  = w_shifted;
                    w_cnt_d = r_cnt + CntW'(1);
                    if (r_cnt == LastCnt) begin
                        if (PARITY_EN) begin
                            w_state_d = StPar;
                        end else begin
                            w_frame_d = w_shifted;
                            w_valid_d = 1'b1;
                            w_perr_d  = 1'b0;
                            w_state_d = StHold;
                        end
                    end
                end
            end

            StPar: begin
                if (bus.en) begin
                    w_frame_d = r_sh;
                    w_perr_d  = (bus.din != ^r_sh);
                    w_valid_d = 1'b1;
                    w_state_d = StHold;
                end
            end

            StHold: begin
                // The handshake is evaluated even on en=0 cycles.
                if (bus.frame_ready) begin
                    w_valid_d = 1'b0;
                    if (w_start) begin
                        w_state_d = StShift;
                        w_cnt_d   = '0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else if (w_start) begin
                    w_overrun_d = 1'b1;
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase

        w_busy_d = (w_state_d == StShift) || (w_state_d == StPar);
    end

    assign bus.frame       = r_frame;
    assign bus.frame_valid = r_valid;
    assign bus.busy        = r_busy;
    assign bus.parity_err  = r_perr;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Directed-vector bench for shift_frame_ctrl (WIDTH=6, PARITY_EN=1): a per-cycle table
// plus hand sequences for stalled bits and asynchronous reset mid-frame.
module tb_shift_frame_ctrl;

    logic clk;
    logic rst;

    shift_frame_ctrl_if #(.WIDTH(6)) bus ();

    shift_frame_ctrl #(
        .WIDTH     (6),
        .PARITY_EN (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       din;
        logic       rdy;
        logic [5:0] frame;
        logic       valid;
        logic       busy;
        logic       perr;
        logic       ovr;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_err;

    function automatic void add(input logic en, input logic din, input logic rdy,
                                input logic [5:0] frame, input logic valid,
                                input logic busy, input logic perr, input logic ovr);
        vec_t v;
        v.en    = en;
        v.din   = din;
        v.rdy   = rdy;
        v.frame = frame;
        v.valid = valid;
        v.busy  = busy;
        v.perr  = perr;
        v.ovr   = ovr;
        tbl.push_back(v);
    endfunction

    // Six data bits MSB-first while the previously loaded frame stays visible.
    function automatic void add_data(input logic [5:0] data, input logic [5:0] old_frame,
                                     input logic old_perr, input logic ovr);
        for (int i = 5; i >= 0; i--) begin
            add(1'b1, data[i], 1'b0, old_frame, 1'b0, 1'b1, old_perr, ovr);
        end
    endfunction

    task automatic check(input string name, input logic [5:0] frame, input logic valid,
                         input logic busy, input logic perr, input logic ovr);
        logic [9:0] act;
        logic [9:0] exp;
        act = {bus.frame, bus.frame_valid, bus.busy, bus.parity_err, bus.overrun};
        exp = {frame, valid, busy, perr, ovr};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got frame=%b valid=%b busy=%b perr=%b ovr=%b, want frame=%b valid=%b busy=%b perr=%b ovr=%b",
                     name, act[9:4], act[3], act[2], act[1], act[0],
                     exp[9:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input string name, input logic en, input logic din, input logic rdy,
                        input logic [5:0] frame, input logic valid, input logic busy,
                        input logic perr, input logic ovr);
        bus.en          = en;
        bus.din         = din;
        bus.frame_ready = rdy;
        @(posedge clk);
        #1;
        check(name, frame, valid, busy, perr, ovr);
    endtask

    initial begin
        logic [7:0] sb;
        logic [5:0] ef;
        n_vec = 0;
        n_err = 0;

        // Idle with din=0 does not start a frame.
        add(1, 0, 0, 6'b000000, 0, 0, 0, 0);
        // Good frame 101100, parity 1.
        add(1, 1, 0, 6'b000000, 0, 1, 0, 0);
        add_data(6'b101100, 6'b000000, 0, 0);
        add(1, 1, 0, 6'b101100, 1, 0, 0, 0);
        add(0, 0, 0, 6'b101100, 1, 0, 0, 0);
        add(0, 0, 1, 6'b101100, 0, 0, 0, 0);
        // Parity error: same word, parity bit 0.
        add(1, 1, 0, 6'b101100, 0, 1, 0, 0);
        add_data(6'b101100, 6'b101100, 0, 0);
        add(1, 0, 0, 6'b101100, 1, 0, 1, 0);
        add(0, 0, 1, 6'b101100, 0, 0, 1, 0);
        // Overrun while held.
        add(1, 1, 0, 6'b101100, 0, 1, 1, 0);
        add_data(6'b101100, 6'b101100, 1, 0);
        add(1, 1, 0, 6'b101100, 1, 0, 0, 0);
        add(1, 1, 0, 6'b101100, 1, 0, 0, 1);
        add(1, 0, 0, 6'b101100, 1, 0, 0, 1);
        add(0, 0, 1, 6'b101100, 0, 0, 0, 1);
        // Back-to-back: accept and start in the same cycle.
        add(1, 1, 0, 6'b101100, 0, 1, 0, 1);
        add_data(6'b101100, 6'b101100, 0, 1);
        add(1, 1, 0, 6'b101100, 1, 0, 0, 1);
        add(1, 1, 1, 6'b101100, 0, 1, 0, 1);
        add_data(6'b010011, 6'b101100, 0, 1);
        add(1, 1, 0, 6'b010011, 1, 0, 0, 1);
        add(0, 0, 1, 6'b010011, 0, 0, 0, 1);

        bus.en          = 1'b0;
        bus.din         = 1'b0;
        bus.frame_ready = 1'b0;
        rst             = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 6'b000000, 0, 0, 0, 0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].en, tbl[i].din, tbl[i].rdy, tbl[i].frame,
                 tbl[i].valid, tbl[i].busy, tbl[i].perr, tbl[i].ovr);
        end

        // Stall: good frame bits separated by three en=0 cycles each.
        sb = 8'b11011001;
        for (int i = 0; i < 8; i++) begin
            ef = (i == 7) ? 6'b101100 : 6'b010011;
            step($sformatf("stall_bit%0d", i), 1, sb[7-i], 0, ef, (i == 7), (i < 7), 0, 1);
            for (int g = 0; g < 3; g++) begin
                step($sformatf("stall_gap%0d_%0d", i, g), 0, 1, 0, ef, (i == 7), (i < 7), 0, 1);
            end
        end
        step("stall_accept", 0, 0, 1, 6'b101100, 0, 0, 0, 1);

        // Asynchronous reset in the middle of SHIFT.
        step("rst_start", 1, 1, 0, 6'b101100, 0, 1, 0, 1);
        step("rst_d0", 1, 0, 0, 6'b101100, 0, 1, 0, 1);
        step("rst_d1", 1, 1, 0, 6'b101100, 0, 1, 0, 1);
        #2;
        bus.en = 1'b0;
        rst    = 1'b0;
        #1;
        check("rst_async", 6'b000000, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("rst_held", 6'b000000, 0, 0, 0, 0);
        rst = 1'b1;
        step("post_rst_start", 1, 1, 0, 6'b000000, 0, 1, 0, 0);
        for (int i = 5; i >= 0; i--) begin
            sb[5:0] = 6'b010011;
            step($sformatf("post_rst_d%0d", i), 1, sb[i], 0, 6'b000000, 0, 1, 0, 0);
        end
        step("post_rst_par", 1, 1, 0, 6'b010011, 1, 0, 0, 0);
        step("post_rst_accept", 0, 0, 1, 6'b010011, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_frame_ctrl.md
Name: shift_frame_ctrl

Overview:
Controller that sequences a serial-in shift register. It detects a start bit on the serial input and shifts a fixed-width data word in MSB-first. It then checks an optional even-parity bit and presents the captured word with a valid/ready handshake. It sits between a serial bit source and any downstream consumer of parallel 6-bit words.

Parameters:
WIDTH, 6, number of data bits per frame (min 2)
PARITY_EN, 1, 1 = one even-parity bit follows the data; 0 = no parity bit

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
din  input  1  serial data bit, sampled only when en=1
en  input  1  bit strobe; each bit (start, data, parity) consumes one en=1 cycle
frame_ready  input  1  consumer accepts frame when frame_valid=1 and frame_ready=1
frame  output  WIDTH  last captured data word, MSB = first data bit received
frame_valid  output  1  captured word available
busy  output  1  frame reception in progress (SHIFT or PAR state)
parity_err  output  1  parity mismatch on the word currently in frame
overrun  output  1  sticky; a start bit arrived while a frame was held unaccepted

Behaviour:
- All outputs and state are registered. rst=0 forces immediately, regardless of clk: state=IDLE, frame=0, frame_valid=0, busy=0, parity_err=0, overrun=0, bit counter=0, shift register=0.
- Reset is asserted asynchronously and released on the clock. Reset mid-frame discards the partial word.
- Cycles with en=0 stall the FSM completely; only the handshake is evaluated.
- States:
  - IDLE: en=1 and din=1 (start bit) -> SHIFT, counter<=0. en=1 and din=0 -> stay.
  - SHIFT: on en=1: sh<={sh[WIDTH-2:0],din}, counter++. When counter==WIDTH-1 on that en:
    - PARITY_EN=1 -> PAR.
    - PARITY_EN=0 -> load frame, frame_valid<=1, parity_err<=0, -> HOLD.
  - PAR: on en=1: frame<=sh, parity_err<=(din != ^sh), frame_valid<=1, -> HOLD.
  - HOLD: frame_valid=1 held.
    - frame_ready=1 -> frame_valid<=0 next edge, -> IDLE.
    - Same cycle also en=1 and din=1 -> start bit accepted, go directly to SHIFT.
    - frame_ready=0 with en=1 and din=1 -> overrun<=1, start bit ignored, frame unchanged.
- Latency: frame_valid rises on the edge that samples the parity bit, or the last data bit when PARITY_EN=0.
- busy=1 exactly while in SHIFT or PAR. busy, frame_valid and the next-state change share the same edge.
- frame and parity_err change only on load. They keep their value after the handshake until the next load.
- overrun clears only on reset.
- Counter width is clog2(WIDTH). No wrap occurs because the counter resets on entry to SHIFT.

Test Plan:
(WIDTH=6, PARITY_EN=1)
- Reset: drive rst=0 in the middle of SHIFT, between clock edges -> all outputs 0 immediately. After release, the next start bit begins a clean frame.
- Good frame: en=1 each cycle, din = 1 (start), 1,0,1,1,0,0, 1 (parity) -> frame=6'b101100, parity_err=0. frame_valid=1 from the parity edge; busy=1 for 7 cycles.
- Parity error: same frame with parity bit 0 -> frame=6'b101100, parity_err=1, frame_valid=1.
- Stall: the good-frame bits with en=0 for 3 cycles between each bit -> same frame, no extra bits shifted, busy held high through the gaps.
- Overrun: frame held with frame_ready=0, then en=1 and din=1 -> overrun=1, frame stays 6'b101100, state stays HOLD. Then frame_ready=1 -> frame_valid=0 next edge, overrun stays 1.
- Back-to-back: in HOLD, frame_ready=1 with en=1 and din=1 in the same cycle -> frame_valid drops and busy rises on the same edge. Next bits 0,1,0,0,1,1 with parity 1 -> frame=6'b010011, parity_err=0.
